// File: rtl/i8088_bus_pkg.sv
// Shared types, defaults and width helpers for the 8088 bus-mastership arbiter.
package i8088_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    GRANT,
    HANDOFF,
    RELEASE
  } arb_state_t;

  localparam int unsigned DEF_N_REQ        = 4;
  localparam int unsigned DEF_MAX_TENURE   = 64;
  localparam int unsigned DEF_HLDA_TIMEOUT = 255;

  // Width of an owner index for n requesters (never narrower than 1 bit).
  function automatic int unsigned owner_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must be able to hold the value lim.
  function automatic int unsigned cnt_w(input int unsigned lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/i8088_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_start,
// wrapping modulo N_REQ.
module i8088_rr_picker
  import i8088_bus_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]            i_req,
  input  logic [owner_w(N_REQ)-1:0]   i_start,
  output logic                        o_valid,
  output logic [owner_w(N_REQ)-1:0]   o_idx
);

  localparam int unsigned OW = owner_w(N_REQ);

  // Scan requesters starting at i_start; the first one found wins.
  always_comb begin : scan
    logic          found;
    logic [OW-1:0] cand;
    found = 1'b0;
    cand  = '0;
    o_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = OW'((32'(i_start) + k) % N_REQ);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        o_idx = cand;
      end
    end
    o_valid = found;
  end

endmodule

// File: rtl/i8088_hold_arbiter.sv
// Bus-mastership arbiter for the 8088 local bus: acquires the bus from the
// processor via HOLD/HLDA, then grants it round-robin with bounded tenure.
module i8088_hold_arbiter
  import i8088_bus_pkg::*;
#(
  parameter int unsigned N_REQ        = DEF_N_REQ,
  parameter int unsigned MAX_TENURE   = DEF_MAX_TENURE,
  parameter int unsigned HLDA_TIMEOUT = DEF_HLDA_TIMEOUT
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_REQ-1:0]          REQ,
  input  logic                      HLDA,
  output logic                      HOLD,
  output logic [N_REQ-1:0]          GNT,
  output logic [owner_w(N_REQ)-1:0] OWNER,
  output logic                      BUS_BUSY,
  output logic                      HLDA_ERR
);

  localparam int unsigned OW = owner_w(N_REQ);
  localparam int unsigned WW = cnt_w(HLDA_TIMEOUT);
  localparam int unsigned TW = cnt_w(MAX_TENURE);

  localparam logic [OW-1:0]    LAST_IDX  = OW'(N_REQ - 1);
  localparam logic [WW-1:0]    WAIT_LAST = WW'(HLDA_TIMEOUT - 1);
  localparam logic [WW-1:0]    WAIT_MAX  = WW'(HLDA_TIMEOUT);
  localparam logic [TW-1:0]    TEN_LAST  = TW'((MAX_TENURE == 0) ? 0 : MAX_TENURE - 1);
  localparam logic [TW-1:0]    TEN_MAX   = TW'(MAX_TENURE);
  localparam logic [N_REQ-1:0] GNT_ONE   = N_REQ'(1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;

  logic             r_hold;
  logic [N_REQ-1:0] r_gnt;
  logic [OW-1:0]    r_owner;
  logic             r_busy;
  logic             r_err;
  logic [WW-1:0]    r_wait_cnt;
  logic [TW-1:0]    r_ten_cnt;

  logic             w_hold_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [OW-1:0]    w_owner_nxt;
  logic             w_busy_nxt;
  logic             w_err_nxt;

  logic             w_any_req;
  logic             w_own_req;
  logic [OW-1:0]    w_rr_start;
  logic             w_pick_valid;
  logic [OW-1:0]    w_pick_idx;
  logic             w_wait_done;
  logic             w_tenure_hit;
  logic             w_grant_exit;
  logic             w_ack_drop;
  logic             w_timeout;

  assign w_any_req  = |REQ;
  assign w_own_req  = REQ[r_owner];
  assign w_rr_start = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

  i8088_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .i_req   (REQ),
    .i_start (w_rr_start),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // The wait counter reads TIMEOUT-1 on the edge where it reaches TIMEOUT.
  assign w_wait_done  = (r_wait_cnt == WAIT_LAST);
  assign w_tenure_hit = (MAX_TENURE != 32'd0) && (r_ten_cnt == TEN_LAST);
  assign w_grant_exit = !w_own_req || w_tenure_hit;
  assign w_ack_drop   = ((r_state == GRANT) || (r_state == HANDOFF)) && !HLDA;
  assign w_timeout    = (r_state == WAIT_ACK) && !HLDA && w_any_req && w_wait_done;

  // State register and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_hold  <= 1'b0;
      r_gnt   <= '0;
      r_owner <= LAST_IDX;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state decode; an HLDA drop outranks tenure expiry and withdrawal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (HLDA && w_pick_valid) w_state_nxt = GRANT;
        else if (!w_any_req)      w_state_nxt = RELEASE;
        else if (w_wait_done)     w_state_nxt = RELEASE;
      end
      GRANT: begin
        if (!HLDA)             w_state_nxt = RELEASE;
        else if (w_grant_exit) w_state_nxt = w_any_req ? HANDOFF : RELEASE;
      end
      HANDOFF: begin
        if (!HLDA)             w_state_nxt = RELEASE;
        else if (w_pick_valid) w_state_nxt = GRANT;
        else                   w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!HLDA) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output values to be registered, derived from the upcoming state.
  always_comb begin
    w_hold_nxt  = (w_state_nxt == WAIT_ACK) || (w_state_nxt == GRANT) ||
                  (w_state_nxt == HANDOFF);
    w_gnt_nxt   = '0;
    w_owner_nxt = r_owner;
    if (w_state_nxt == GRANT) begin
      if (r_state == GRANT) begin
        w_gnt_nxt = r_gnt;
      end else begin
        w_gnt_nxt   = GNT_ONE << w_pick_idx;
        w_owner_nxt = w_pick_idx;
      end
    end
    w_busy_nxt = |w_gnt_nxt;
    w_err_nxt  = r_err | w_ack_drop | w_timeout;
  end

  // Wait and tenure counters; holding them at zero outside their state
  // gives the clear-on-entry behaviour, since GRANT is never re-entered
  // directly from GRANT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wait_cnt <= '0;
      r_ten_cnt  <= '0;
    end else begin
      if (r_state != WAIT_ACK)      r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;

      if (r_state != GRANT)         r_ten_cnt <= '0;
      else if (r_ten_cnt != TEN_MAX) r_ten_cnt <= r_ten_cnt + 1'b1;
    end
  end

  assign HOLD     = r_hold;
  assign GNT      = r_gnt;
  assign OWNER    = r_owner;
  assign BUS_BUSY = r_busy;
  assign HLDA_ERR = r_err;

endmodule

// File: tb/tb_i8088_hold_arbiter.sv
// Randomized bench for i8088_hold_arbiter against a behavioural bus model.
module tb_i8088_hold_arbiter;

  localparam int N    = 4;
  localparam int MAXT = 8;
  localparam int TMO  = 16;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] REQ   = '0;
  logic       HLDA  = 1'b0;
  logic       HOLD;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       BUS_BUSY;
  logic       HLDA_ERR;

  i8088_hold_arbiter #(
    .N_REQ        (N),
    .MAX_TENURE   (MAXT),
    .HLDA_TIMEOUT (TMO)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .REQ      (REQ),
    .HLDA     (HLDA),
    .HOLD     (HOLD),
    .GNT      (GNT),
    .OWNER    (OWNER),
    .BUS_BUSY (BUS_BUSY),
    .HLDA_ERR (HLDA_ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: who holds the bus, and what phase of ownership we are in.
  bit m_hold, m_err, m_wait, m_gap, m_rel;
  int m_gnt, m_owner, m_wait_n, m_ten_n;

  function automatic int next_winner(input logic [3:0] req, input int from);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (from + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_err = 0; m_wait = 0; m_gap = 0; m_rel = 0;
    m_gnt = -1; m_owner = N - 1; m_wait_n = 0; m_ten_n = 0;
  endtask

  task automatic to_release();
    m_gnt = -1; m_hold = 0; m_rel = 1;
  endtask

  task automatic start_grant(input logic [3:0] req);
    m_gnt = next_winner(req, m_owner);
    m_owner = m_gnt;
    m_ten_n = 0;
  endtask

  task automatic model_step(input logic [3:0] req, input bit ack);
    if (m_rel) begin
      if (!ack) m_rel = 0;
    end else if (m_wait) begin
      m_wait_n++;
      if (ack && req != 0)      begin m_wait = 0; start_grant(req); end
      else if (req == 0)        begin m_wait = 0; to_release(); end
      else if (m_wait_n == TMO) begin m_wait = 0; m_err = 1; to_release(); end
    end else if (m_gnt >= 0) begin
      m_ten_n++;
      if (!ack) begin
        m_err = 1; to_release();
      end else if (!req[m_owner] || (MAXT != 0 && m_ten_n == MAXT)) begin
        if (req != 0) begin m_gnt = -1; m_gap = 1; end
        else to_release();
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (!ack)          begin m_err = 1; to_release(); end
      else if (req != 0) start_grant(req);
      else               to_release();
    end else if (req != 0) begin
      m_wait = 1; m_wait_n = 0; m_hold = 1;
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] eg;
    eg = (m_gnt >= 0) ? 4'(1 << m_gnt) : 4'b0;
    check("HOLD", HOLD, m_hold);
    check("GNT", GNT, eg);
    check("OWNER", OWNER, m_owner);
    check("BUS_BUSY", BUS_BUSY, m_gnt >= 0);
    check("HLDA_ERR", HLDA_ERR, m_err);
  endtask

  // Processor side. 0: normal ack, 1: never ack, 2: always drop HLDA two
  // cycles into a grant, 3: occasionally drop HLDA two cycles into a grant.
  task automatic processor(input int mode);
    if (mode == 1) begin
      HLDA = 1'b0;
    end else if (m_hold && !HLDA) begin
      if ($urandom_range(0, 1) == 0) HLDA = 1'b1;
    end else if (!m_hold && HLDA) begin
      if ($urandom_range(0, 1) == 0) HLDA = 1'b0;
    end else if (mode >= 2 && m_gnt >= 0 && m_ten_n == 2 &&
                 (mode == 2 || $urandom_range(0, 7) == 0)) begin
      HLDA = 1'b0;
    end
  endtask

  // Observed DUT grant runs (value, length) and first completed HOLD-high run.
  int run_val[$];
  int run_len[$];
  int cur_val, cur_len, hold_run, hold_first;
  bit any_gnt;

  function automatic int rv(input int i);
    if (i >= 0 && i < run_val.size()) return run_val[i];
    return -1;
  endfunction

  function automatic int rl(input int i);
    if (i >= 0 && i < run_len.size()) return run_len[i];
    return -1;
  endfunction

  function automatic int first_grant();
    for (int i = 0; i < run_val.size(); i++) if (run_val[i] != 0) return i;
    return -1000;
  endfunction

  task automatic run_phase(input int cycles, input int req_mode,
                           input logic [3:0] req_fix, input int ack_mode);
    run_val.delete(); run_len.delete();
    cur_val = -1; cur_len = 0; hold_run = 0; hold_first = 0; any_gnt = 0;
    REQ = (req_mode == 0) ? req_fix : 4'($urandom);
    repeat (cycles) begin
      @(posedge CLK);
      model_step(REQ, HLDA);
      #1;
      compare_outputs();
      if (int'(GNT) == cur_val) cur_len++;
      else begin
        if (cur_len > 0) begin run_val.push_back(cur_val); run_len.push_back(cur_len); end
        cur_val = int'(GNT); cur_len = 1;
      end
      if (GNT != 0) any_gnt = 1;
      if (HOLD) hold_run++;
      else begin
        if (hold_first == 0 && hold_run > 0) hold_first = hold_run;
        hold_run = 0;
      end
      if (req_mode == 1)
        for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) REQ[b] = ~REQ[b];
      processor(ack_mode);
    end
    run_val.push_back(cur_val); run_len.push_back(cur_len);
  endtask

  task automatic do_reset();
    RESET = 1'b1; HLDA = 1'b0; REQ = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_HOLD", HOLD, 0);
    check("rst_OWNER", OWNER, N - 1);
    RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    int s;
    int guard;
    int exp_seq[5];
    exp_seq = '{1, 2, 4, 8, 1};

    // Asynchronous reset while GNT=0010.
    do_reset();
    REQ = 4'b0010;
    guard = 0;
    while (m_gnt != 1 && guard < 40) begin
      @(posedge CLK);
      model_step(REQ, HLDA);
      #1;
      compare_outputs();
      processor(0);
      guard++;
    end
    check("reach_grant", GNT, 4'b0010);
    #2 RESET = 1'b1;
    #1;
    check("async_HOLD", HOLD, 0);
    check("async_GNT", GNT, 0);
    check("async_OWNER", OWNER, 3);
    check("async_BUSY", BUS_BUSY, 0);
    check("async_ERR", HLDA_ERR, 0);

    // Every master requesting: 0,1,2,3,0 with one dead cycle between grants.
    do_reset();
    run_phase(70, 0, 4'b1111, 0);
    s = first_grant();
    for (int g = 0; g < 5; g++) begin
      check("rr_order", rv(s + 2 * g), exp_seq[g]);
      if (g < 4) check("rr_gap", rl(s + 2 * g + 1), 1);
    end
    check("rr_hold_cont", hold_first, 0);

    // Tenure cap with two requesters.
    do_reset();
    run_phase(40, 0, 4'b0011, 0);
    s = first_grant();
    check("ten_first", rv(s), 1);
    check("ten_len0", rl(s), MAXT);
    check("ten_gap", rl(s + 1), 1);
    check("ten_second", rv(s + 2), 2);
    check("ten_len1", rl(s + 2), MAXT);

    // HLDA never arrives.
    do_reset();
    run_phase(40, 0, 4'b0001, 1);
    check("tmo_hold_len", hold_first, TMO);
    check("tmo_no_gnt", any_gnt, 0);
    check("tmo_err", HLDA_ERR, 1);

    // Single requester, then withdrawal and release.
    do_reset();
    run_phase(20, 0, 4'b0100, 0);
    run_phase(10, 0, 4'b0000, 0);
    check("single_released", HOLD, 0);

    // HLDA dropped during a grant.
    do_reset();
    run_phase(30, 0, 4'b0100, 2);
    check("viol_err", HLDA_ERR, 1);

    // Random traffic, well-behaved processor, then with occasional violations.
    do_reset();
    run_phase(2000, 1, 4'b0000, 0);
    do_reset();
    run_phase(600, 1, 4'b0000, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
